// File: rtl/dehaze_pkg.sv
// Shared constants for the dehaze filter pipeline: pixel width, default frame
// geometry and the row-major index of each 3x3 window tap.
package dehaze_pkg;
    localparam int PIX_W          = 8;
    localparam int IMG_WIDTH_DEF  = 512;
    localparam int IMG_HEIGHT_DEF = 512;
    localparam int N_TAPS         = 9;

    localparam int W_TL = 0;
    localparam int W_TM = 1;
    localparam int W_TR = 2;
    localparam int W_ML = 3;
    localparam int W_C  = 4;
    localparam int W_MR = 5;
    localparam int W_BL = 6;
    localparam int W_BM = 7;
    localparam int W_BR = 8;
endpackage

// File: rtl/line_buffer.sv
// One image line of delay storage with a registered read port; a read and a
// write to the same address in one cycle return the previous contents.
module line_buffer #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [0:DEPTH-1];
    logic [WIDTH-1:0] rdata_d;
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = mem[raddr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= {WIDTH{1'b0}};
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3x3 tap
// register turn a raster pixel stream into one registered window per interior pixel.
module window_3x3_gen
    import dehaze_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int PIX_W      = dehaze_pkg::PIX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             out_valid,
    output logic [PIX_W-1:0] w0,
    output logic [PIX_W-1:0] w1,
    output logic [PIX_W-1:0] w2,
    output logic [PIX_W-1:0] w3,
    output logic [PIX_W-1:0] w4,
    output logic [PIX_W-1:0] w5,
    output logic [PIX_W-1:0] w6,
    output logic [PIX_W-1:0] w7,
    output logic [PIX_W-1:0] w8,
    output logic             out_eol,
    output logic             out_eof
);
    localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    logic [CW-1:0] col_q, col_d, beat_col_s;
    logic [RW-1:0] row_q, row_d, beat_row_s;
    logic          last_col_s, last_row_s, emit_s;
    logic [PIX_W-1:0] lb1_rd_s, lb2_rd_s;

    logic [N_TAPS-1:0][PIX_W-1:0] tap_q, tap_d;
    logic [N_TAPS-1:0][PIX_W-1:0] win_q, win_d;
    logic out_valid_q, out_valid_d;
    logic out_eol_q, out_eol_d;
    logic out_eof_q, out_eof_d;

    // Beat coordinates (sof forces 0,0) and the position of the following beat.
    always_comb begin
        beat_col_s = in_sof ? {CW{1'b0}} : col_q;
        beat_row_s = in_sof ? {RW{1'b0}} : row_q;
        last_col_s = (beat_col_s == CW'(IMG_WIDTH - 1));
        last_row_s = (beat_row_s == RW'(IMG_HEIGHT - 1));
        emit_s     = in_valid && (beat_row_s >= RW'(2)) && (beat_col_s >= CW'(2));
        if (in_valid) begin
            if (last_col_s) begin
                col_d = {CW{1'b0}};
                row_d = last_row_s ? {RW{1'b0}} : (beat_row_s + RW'(1));
            end else begin
                col_d = beat_col_s + CW'(1);
                row_d = beat_row_s;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
    end

    // The read port is addressed with the next beat's column so the older rows
    // of column c are already registered when that beat arrives; a sof-forced
    // mismatch only lands on row 0, whose buffer contents are never emitted.
    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W), .AW(CW)) u_lb1 (
        .clk   (clk),
        .rst   (rst),
        .we    (in_valid),
        .waddr (beat_col_s),
        .wdata (in_pixel),
        .raddr (col_d),
        .rdata (lb1_rd_s)
    );

    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W), .AW(CW)) u_lb2 (
        .clk   (clk),
        .rst   (rst),
        .we    (in_valid),
        .waddr (beat_col_s),
        .wdata (lb1_rd_s),
        .raddr (col_d),
        .rdata (lb2_rd_s)
    );

    // Tap shift (newest column at index 2 of each row) and output capture.
    always_comb begin
        tap_d = tap_q;
        if (in_valid) begin
            for (int k = 0; k < 3; k++) begin
                tap_d[3*k]     = tap_q[3*k + 1];
                tap_d[3*k + 1] = tap_q[3*k + 2];
            end
            tap_d[W_TR] = lb2_rd_s;
            tap_d[W_MR] = lb1_rd_s;
            tap_d[W_BR] = in_pixel;
        end else begin
            tap_d = tap_q;
        end
        win_d       = emit_s ? tap_d : win_q;
        out_valid_d = emit_s;
        out_eol_d   = emit_s && last_col_s;
        out_eof_d   = emit_s && last_col_s && last_row_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q       <= {CW{1'b0}};
            row_q       <= {RW{1'b0}};
            tap_q       <= '0;
            win_q       <= '0;
            out_valid_q <= 1'b0;
            out_eol_q   <= 1'b0;
            out_eof_q   <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            tap_q       <= tap_d;
            win_q       <= win_d;
            out_valid_q <= out_valid_d;
            out_eol_q   <= out_eol_d;
            out_eof_q   <= out_eof_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_eol   = out_eol_q;
    assign out_eof   = out_eof_q;
    assign w0 = win_q[W_TL];
    assign w1 = win_q[W_TM];
    assign w2 = win_q[W_TR];
    assign w3 = win_q[W_ML];
    assign w4 = win_q[W_C];
    assign w5 = win_q[W_MR];
    assign w6 = win_q[W_BL];
    assign w7 = win_q[W_BM];
    assign w8 = win_q[W_BR];
endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen: a 5x4 frame instance and a 3x3 frame instance.
module tb_window_3x3_gen;
    localparam int W = 5;
    localparam int H = 4;
    localparam int N = W * H;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid, in_sof;
    logic [7:0] in_pixel;
    logic       out_valid, out_eol, out_eof;
    logic [7:0] w0, w1, w2, w3, w4, w5, w6, w7, w8;
    logic [8:0][7:0] wv;
    assign wv = {w8, w7, w6, w5, w4, w3, w2, w1, w0};

    logic       s_in_valid, s_in_sof;
    logic [7:0] s_in_pixel;
    logic       s_out_valid, s_out_eol, s_out_eof;
    logic [7:0] s_w0, s_w1, s_w2, s_w3, s_w4, s_w5, s_w6, s_w7, s_w8;
    logic [8:0][7:0] s_wv;
    assign s_wv = {s_w8, s_w7, s_w6, s_w5, s_w4, s_w3, s_w2, s_w1, s_w0};

    window_3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
        .out_valid(out_valid), .w0(w0), .w1(w1), .w2(w2), .w3(w3), .w4(w4),
        .w5(w5), .w6(w6), .w7(w7), .w8(w8), .out_eol(out_eol), .out_eof(out_eof)
    );

    window_3x3_gen #(.IMG_WIDTH(3), .IMG_HEIGHT(3), .PIX_W(8)) dut_s (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_sof(s_in_sof), .in_pixel(s_in_pixel),
        .out_valid(s_out_valid), .w0(s_w0), .w1(s_w1), .w2(s_w2), .w3(s_w3), .w4(s_w4),
        .w5(s_w5), .w6(s_w6), .w7(s_w7), .w8(s_w8), .out_eol(s_out_eol), .out_eof(s_out_eof)
    );

    int errors = 0;
    int checks = 0;
    int gap_bad;
    logic            cap_v   [0:N-1];
    logic            cap_eol [0:N-1];
    logic            cap_eof [0:N-1];
    logic [8:0][7:0] cap_w   [0:N-1];

    function automatic logic [7:0] pix(input logic [7:0] base, input int r, input int c);
        return base + 8'(16 * r + c);
    endfunction

    function automatic logic [8:0][7:0] exp_win(input logic [7:0] base, input int r, input int c);
        logic [8:0][7:0] e;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                e[3*i + j] = pix(base, r - 2 + i, c - 2 + j);
        return e;
    endfunction

    task automatic send(input logic [7:0] p, input logic sof);
        in_valid = 1'b1; in_sof = sof; in_pixel = p;
        @(posedge clk); #1;
        in_valid = 1'b0; in_sof = 1'b0;
    endtask

    // Sends one frame, capturing the output seen one edge after each beat.
    task automatic run_frame(input logic [7:0] base, input int maxgap, input logic use_sof);
        logic [8:0][7:0] held;
        int g;
        gap_bad = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                send(pix(base, r, c), use_sof && (r == 0) && (c == 0));
                cap_v[r*W + c]   = out_valid;
                cap_eol[r*W + c] = out_eol;
                cap_eof[r*W + c] = out_eof;
                cap_w[r*W + c]   = wv;
                held = wv;
                g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
                repeat (g) begin
                    @(posedge clk); #1;
                    if (out_valid !== 1'b0 || wv !== held) gap_bad++;
                end
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0; in_sof = 1'b0; in_pixel = 8'h00;
        s_in_valid = 1'b0; s_in_sof = 1'b0; s_in_pixel = 8'h00;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, out_eol, out_eof} !== 3'b000 || wv !== 72'h0) begin
            errors++;
            $display("FAIL reset_state: got v/eol/eof=%b%b%b w=%h, want 000 w=0", out_valid, out_eol, out_eof, wv);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_frame;
        int nwin = 0;
        run_frame(8'h00, 0, 1'b1);
        for (int i = 0; i < N; i++) begin
            logic ev = (i / W >= 2) && (i % W >= 2);
            checks++;
            if (cap_v[i] !== ev) begin
                errors++;
                $display("FAIL single_valid[%0d]: got %b want %b", i, cap_v[i], ev);
            end
            if (ev) begin
                nwin++;
                checks++;
                if (cap_w[i] !== exp_win(8'h00, i / W, i % W) || cap_eol[i] !== (i % W == W - 1) || cap_eof[i] !== (i == N - 1)) begin
                    errors++;
                    $display("FAIL single_win[%0d]: got w=%h eol=%b eof=%b want w=%h", i, cap_w[i], cap_eol[i], cap_eof[i], exp_win(8'h00, i / W, i % W));
                end
            end
        end
        checks++;
        if (nwin != 6) begin errors++; $display("FAIL single_count: got %0d want 6", nwin); end
        checks++;
        if (cap_w[12] !== 72'h22_21_20_12_11_10_02_01_00) begin
            errors++; $display("FAIL single_first: got %h want 222120121110020100", cap_w[12]);
        end
        checks++;
        if (cap_w[19][8] !== 8'h34 || cap_eol[14] !== 1'b1 || cap_eof[14] !== 1'b0 || cap_eof[19] !== 1'b1) begin
            errors++; $display("FAIL single_last: got w8=%h eol3=%b eof3=%b eof6=%b want 34 1 0 1", cap_w[19][8], cap_eol[14], cap_eof[14], cap_eof[19]);
        end
    endtask

    task automatic test_gaps;
        run_frame(8'h00, 3, 1'b1);
        for (int i = 0; i < N; i++) begin
            logic ev = (i / W >= 2) && (i % W >= 2);
            checks++;
            if (cap_v[i] !== ev || (ev && (cap_w[i] !== exp_win(8'h00, i / W, i % W) || cap_eof[i] !== (i == N - 1)))) begin
                errors++;
                $display("FAIL gaps_win[%0d]: got v=%b w=%h want v=%b w=%h", i, cap_v[i], cap_w[i], ev, exp_win(8'h00, i / W, i % W));
            end
        end
        checks++;
        if (gap_bad != 0) begin errors++; $display("FAIL gaps_hold: got %0d bad idle cycles want 0", gap_bad); end
    endtask

    task automatic test_back_to_back;
        run_frame(8'h00, 0, 1'b1);
        run_frame(8'h80, 0, 1'b1);
        for (int i = 0; i < N; i++) begin
            logic ev = (i / W >= 2) && (i % W >= 2);
            checks++;
            if (cap_v[i] !== ev || (ev && cap_w[i] !== exp_win(8'h80, i / W, i % W))) begin
                errors++;
                $display("FAIL b2b_win[%0d]: got v=%b w=%h want v=%b w=%h", i, cap_v[i], cap_w[i], ev, exp_win(8'h80, i / W, i % W));
            end
        end
        checks++;
        if (cap_w[12] !== 72'hA2_A1_A0_92_91_90_82_81_80) begin
            errors++; $display("FAIL b2b_first: got %h want a2a1a0929190828180", cap_w[12]);
        end
    endtask

    task automatic test_reset_mid_frame;
        for (int i = 0; i < 7; i++) send(pix(8'h00, i / W, i % W), i == 0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_eol, out_eof} !== 3'b000 || wv !== 72'h0) begin
            errors++;
            $display("FAIL reset_mid: got v/eol/eof=%b%b%b w=%h want 000 w=0", out_valid, out_eol, out_eof, wv);
        end
        @(posedge clk); #3 rst = 1'b0;
        run_frame(8'h00, 0, 1'b0);
        for (int i = 0; i < N; i++) begin
            logic ev = (i / W >= 2) && (i % W >= 2);
            checks++;
            if (cap_v[i] !== ev || (ev && (cap_w[i] !== exp_win(8'h00, i / W, i % W) || cap_eof[i] !== (i == N - 1)))) begin
                errors++;
                $display("FAIL reset_frame[%0d]: got v=%b w=%h want v=%b w=%h", i, cap_v[i], cap_w[i], ev, exp_win(8'h00, i / W, i % W));
            end
        end
    endtask

    task automatic test_sof_resync;
        for (int i = 0; i < 3; i++) send(8'hE0 + 8'(i), 1'b0);
        run_frame(8'h00, 0, 1'b1);
        for (int i = 0; i < N; i++) begin
            logic ev = (i / W >= 2) && (i % W >= 2);
            checks++;
            if (cap_v[i] !== ev || (ev && (cap_w[i] !== exp_win(8'h00, i / W, i % W) || cap_eol[i] !== (i % W == W - 1)))) begin
                errors++;
                $display("FAIL resync_win[%0d]: got v=%b w=%h want v=%b w=%h", i, cap_v[i], cap_w[i], ev, exp_win(8'h00, i / W, i % W));
            end
        end
    endtask

    task automatic test_min_frame;
        int nwin = 0;
        for (int i = 1; i <= 9; i++) begin
            s_in_valid = 1'b1; s_in_sof = (i == 1); s_in_pixel = 8'(i);
            @(posedge clk); #1;
            s_in_valid = 1'b0; s_in_sof = 1'b0;
            if (s_out_valid === 1'b1) nwin++;
        end
        checks++;
        if (nwin != 1) begin errors++; $display("FAIL min_count: got %0d want 1", nwin); end
        checks++;
        if (s_wv !== 72'h09_08_07_06_05_04_03_02_01 || s_out_eol !== 1'b1 || s_out_eof !== 1'b1 || s_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL min_win: got w=%h v=%b eol=%b eof=%b want 090807060504030201 1 1 1", s_wv, s_out_valid, s_out_eol, s_out_eof);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_gaps();
        test_back_to_back();
        test_reset_mid_frame();
        test_sof_resync();
        test_min_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
